divider_controller: RTL and testbench

//  FSM sequencing the 32-bit restoring divider. Drives the remainder register
//  (SLL_ctrl, SRL_ctrl, w_ctrl, ready) and the ALU operation select (ALU_sub).
//  It decides restore vs keep from ALU_Carry.

---
 rtl/divider_controller.sv | 111 +++++++++++
 tb/tb_divider_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_controller.sv
// Control FSM for a 32-bit restoring divider.
// Sequences remainder register and ALU; all outputs registered.
module divider_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALU_Carry,
    output logic             ALU_sub,
    output logic             w_ctrl,
    output logic             SLL_ctrl,
    output logic             SRL_ctrl,
    output logic             ready,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_SUB   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    logic [2:0]       state_q, state_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             w_q, w_d;
    logic             sll_q, sll_d;
    logic             srl_q, srl_d;
    logic             ready_q, ready_d;

    // Next-state, borrow flag and iteration counter
    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOAD: state_d = S_SUB;
            S_SUB: begin
                neg_d   = ~ALU_Carry;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_LAST) ? S_FIX : S_SUB;
            end
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    // Moore outputs decoded from the state being entered, so they are
    // already settled when the remainder register samples on negedge
    always_comb begin
        sub_d   = 1'b0;
        w_d     = 1'b0;
        sll_d   = 1'b0;
        srl_d   = 1'b0;
        ready_d = 1'b0;
        unique case (state_d)
            S_SUB: begin
                w_d   = 1'b1;
                sub_d = 1'b1;
            end
            S_SHIFT: begin
                sll_d = 1'b1;
                w_d   = neg_d;
                sub_d = ~neg_d;
            end
            S_FIX:  srl_d   = 1'b1;
            S_DONE: ready_d = 1'b1;
            default: ;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            w_q     <= 1'b0;
            sll_q   <= 1'b0;
            srl_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            w_q     <= w_d;
            sll_q   <= sll_d;
            srl_q   <= srl_d;
            ready_q <= ready_d;
        end
    end

    assign ALU_sub  = sub_q;
    assign w_ctrl   = w_q;
    assign SLL_ctrl = sll_q;
    assign SRL_ctrl = srl_q;
    assign ready    = ready_q;
    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_divider_controller.sv
// Scoreboard bench for divider_controller with a behavioural
// remainder register / ALU model closing the carry loop.
module tb_divider_controller;

    logic       clk;
    logic       rst;
    logic       ALU_Carry;
    logic       ALU_sub;
    logic       w_ctrl;
    logic       SLL_ctrl;
    logic       SRL_ctrl;
    logic       ready;
    logic [5:0] iter_cnt;

    divider_controller #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .ALU_Carry(ALU_Carry),
        .ALU_sub  (ALU_sub),
        .w_ctrl   (w_ctrl),
        .SLL_ctrl (SLL_ctrl),
        .SRL_ctrl (SRL_ctrl),
        .ready    (ready),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        check;
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic [10:0] exp_q[$];
    res_t        res_q[$];

    int n_cmp;
    int n_bad;

    logic [31:0] cur_dvd;
    logic [31:0] cur_dvs;
    int          carry_mode;
    logic [63:0] hi;
    logic [31:0] lo;

    // {ready, SRL, SLL, w, sub, iter_cnt} expected k edges after release
    function automatic logic [10:0] exp_vec(input int k, input logic [31:0] q);
        logic       rdy, srl, sll, w, sub, qb;
        int         cnt;
        rdy = 0; srl = 0; sll = 0; w = 0; sub = 0;
        if (k <= 64) begin
            cnt = (k - 1) / 2;
            if (k % 2 == 1) begin
                w = 1; sub = 1;
            end else begin
                qb  = q[32 - k / 2];
                sll = 1; w = ~qb; sub = qb;
            end
        end else begin
            cnt = 32;
            if (k == 65) srl = 1;
            else rdy = 1;
        end
        return {rdy, srl, sll, w, sub, 6'(cnt)};
    endfunction

    // Remainder register and ALU, sampling controls on negedge
    always @(negedge clk) begin
        logic c;
        c = 1'($urandom);
        if (rst) begin
            hi = {63'b0, cur_dvd[31]};
            lo = {cur_dvd[30:0], 1'b0};
        end else if (w_ctrl && ALU_sub && !SLL_ctrl) begin
            c  = (hi >= {32'b0, cur_dvs});
            hi = hi - {32'b0, cur_dvs};
        end else if (SLL_ctrl) begin
            if (w_ctrl) hi = hi + {32'b0, cur_dvs};
            hi = {hi[62:0], lo[31]};
            lo = {lo[30:0], ALU_sub};
        end else if (SRL_ctrl) begin
            hi = hi >> 1;
        end
        if (carry_mode == 1) ALU_Carry = 1'b1;
        else if (carry_mode == 2) ALU_Carry = 1'b0;
        else ALU_Carry = c;
    end

    // Monitor: one control vector per edge, one result per ready rise
    logic rdy_prev;
    initial begin
        rdy_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [10:0] e, g;
                e = exp_q.pop_front();
                g = {ready, SRL_ctrl, SLL_ctrl, w_ctrl, ALU_sub, iter_cnt};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL ctrl t=%0t got=%b exp=%b", $time, g, e);
                end
            end
            if (ready && !rdy_prev) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL result unexpected ready t=%0t", $time);
                end else begin
                    res_t x;
                    x = res_q.pop_front();
                    if (x.check) begin
                        n_cmp++;
                        if (lo !== x.q || hi[31:0] !== x.r) begin
                            n_bad++;
                            $display("FAIL result q=%h r=%h exp q=%h r=%h",
                                     lo, hi[31:0], x.q, x.r);
                        end
                    end
                end
            end
            rdy_prev = ready;
        end
    end

    task automatic run(input logic [31:0] dvd, input logic [31:0] dvs,
                       input int mode, input int nrst, input int pulse_at);
        logic [31:0] q, r;
        res_t        x;
        int          k;
        int          pa;
        cur_dvd    = dvd;
        cur_dvs    = dvs;
        carry_mode = mode;
        if (mode == 1) q = '1;
        else if (mode == 2) q = '0;
        else q = (dvs == 0) ? 32'hFFFF_FFFF : dvd / dvs;
        r = (dvs == 0) ? dvd : dvd % dvs;
        x.check = (mode == 0);
        x.q = q;
        x.r = r;
        res_q.push_back(x);
        for (int i = 0; i < nrst; i++) begin
            rst = 1'b1;
            exp_q.push_back(11'd0);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        pa = pulse_at;
        k = 1;
        while (k <= 76) begin
            if (k == pa) begin
                rst = 1'b1;
                exp_q.push_back(11'd0);
                @(posedge clk);
                #2;
                rst = 1'b0;
                pa = 0;
                k = 1;
            end else begin
                exp_q.push_back(exp_vec(k, q));
                @(posedge clk);
                #2;
                k++;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ALU_Carry = 1'b0;
        carry_mode = 0;
        cur_dvd = 0;
        cur_dvs = 1;
        @(posedge clk);
        #2;
        run(32'd100, 32'd7, 0, 3, 0);
        run(32'hDEAD_BEEF, 32'd3, 1, 2, 0);
        run(32'h0BAD_F00D, 32'd9, 2, 2, 0);
        run(32'd1000, 32'd13, 0, 2, 20);
        run(32'hFFFF_FFFF, 32'd1, 0, 20, 0);
        run(32'h1234_5678, 32'd0, 0, 1, 0);
        run(32'd5, 32'hFFFF_FFFF, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run(a, b, 0, 1 + i % 3, (i == 3) ? 35 : 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain ctrl=%0d res=%0d left, need 0",
                     exp_q.size(), res_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
